// File: rtl/nsc8_output_display.sv
// Converts each new NSC8 output value to packed BCD with a serial double-dabble engine
// and scans the result onto a time-multiplexed common-cathode 7-segment display.
module nsc8_output_display #(
    parameter int N        = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N-1:0]          output_contents,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_reg;
    logic [N-1:0]          last_value_reg;
    logic [N-1:0]          bin_reg;
    logic [4*DIGITS-1:0]   work_reg;
    logic [4*DIGITS-1:0]   bcd_reg;
    logic [CW-1:0]         count_reg;
    logic                  bcd_valid_reg;
    logic                  busy_reg;
    logic [PW-1:0]         prescaler_reg;
    logic [IW-1:0]         idx_reg;

    logic [4*DIGITS-1:0]   work_adj;
    logic [4*DIGITS-1:0]   work_next;
    logic [6:0]            digit_seg [DIGITS];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Add-3 correction on every nibble before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                       ? work_reg[4*gi +: 4] + 4'd3
                                       : work_reg[4*gi +: 4];
        end
    endgenerate

    assign work_next = {work_adj[4*DIGITS-2:0], bin_reg[N-1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_value_reg <= '0;
            bin_reg        <= '0;
            work_reg       <= '0;
            bcd_reg        <= '0;
            count_reg      <= '0;
            bcd_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            bcd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (output_contents != last_value_reg) begin
                        bin_reg        <= output_contents;
                        work_reg       <= '0;
                        last_value_reg <= output_contents;
                        count_reg      <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg  <= work_next;
                    bin_reg   <= bin_reg << 1;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(N - 1)) begin
                        bcd_reg       <= work_next;
                        bcd_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Free-running digit scan, independent of conversion activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_reg <= '0;
            idx_reg       <= '0;
        end else if (prescaler_reg == PW'(SCAN_DIV - 1)) begin
            prescaler_reg <= '0;
            idx_reg       <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
        end else begin
            prescaler_reg <= prescaler_reg + PW'(1);
        end
    end

    // A digit is blank when it and every more significant nibble are zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic blank;
            assign blank = (BLANK_LZ != 0) && (gi != 0)
                        && (bcd_reg[4*DIGITS-1:4*gi] == '0);
            assign digit_seg[gi] = blank ? 7'h00 : seg_decode(bcd_reg[4*gi +: 4]);
            assign digit_en[gi]  = (idx_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        seg = 7'h00;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_reg == IW'(k)) seg = digit_seg[k];
        end
    end

    assign bcd       = bcd_reg;
    assign bcd_valid = bcd_valid_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_nsc8_output_display.sv
// Random and directed stimulus for nsc8_output_display, compared every cycle against
// a transaction-level decimal model of conversion and display scanning.
module tb_nsc8_output_display;

    localparam int N        = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      oc = '0;

    logic [11:0]       bcd_a, bcd_b;
    logic              valid_a, valid_b, busy_a, busy_b;
    logic [2:0]        en_a, en_b;
    logic [6:0]        seg_a, seg_b;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    nsc8_output_display #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
        .clk(clk), .reset_n(reset_n), .output_contents(oc),
        .bcd(bcd_a), .bcd_valid(valid_a), .busy(busy_a),
        .digit_en(en_a), .seg(seg_a)
    );

    nsc8_output_display #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .output_contents(oc),
        .bcd(bcd_b), .bcd_valid(valid_b), .busy(busy_b),
        .digit_en(en_b), .seg(seg_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k, input bit blank_lz);
        logic [6:0] tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (blank_lz && k > 0 && v < pow10(k)) return 7'h00;
        return tab[(v / pow10(k)) % 10];
    endfunction

    // Model: a conversion takes N cycles of busy, then the shown value changes.
    int m_last, m_cnt, m_pending, m_shown, m_cyc;
    bit m_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_last <= 0; m_cnt <= 0; m_pending <= 0;
            m_shown <= 0; m_cyc <= 0; m_valid <= 1'b0;
        end else begin
            m_cyc   <= m_cyc + 1;
            m_valid <= 1'b0;
            if (m_cnt == 0) begin
                if (int'(oc) != m_last) begin
                    m_last    <= int'(oc);
                    m_pending <= int'(oc);
                    m_cnt     <= N;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_shown <= m_pending;
                    m_valid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int idx;
        idx = (m_cyc / SCAN_DIV) % DIGITS;
        if (valid_a) pulses++;
        check("busy",     32'(busy_a),  32'(m_cnt != 0));
        check("valid",    32'(valid_a), 32'(m_valid));
        check("bcd",      32'(bcd_a),   32'(to_bcd(m_shown)));
        check("digit_en", 32'(en_a),    32'(1 << idx));
        check("seg_lz",   32'(seg_a),   32'(exp_seg(m_shown, idx, 1'b1)));
        check("bcd_nb",   32'(bcd_b),   32'(to_bcd(m_shown)));
        check("en_nb",    32'(en_b),    32'(1 << idx));
        check("seg_nb",   32'(seg_b),   32'(exp_seg(m_shown, idx, 1'b0)));
    end

    task automatic apply(input int v, input int hold);
        oc = 8'(v);
        $display("apply value=%0d hold=%0d", v, hold);
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        int first_edge;
        reset_n = 1'b0;
        oc = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Zero input after reset: nothing converts, display shows 0 with blanking.
        pulses = 0;
        apply(0, 50);
        check("zero_pulses", 32'(pulses), 32'd0);

        // Latency: capture edge counts as edge 1, bcd/valid appear on edge 9.
        oc = 8'd255;
        $display("apply value=255 latency probe");
        first_edge = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (valid_a && first_edge == 0) first_edge = e;
        end
        check("latency", 32'(first_edge), 32'd9);
        check("bcd_255", 32'(bcd_a), 32'h255);
        repeat (20) @(negedge clk);

        apply(7, 30);
        check("bcd_7", 32'(bcd_a), 32'h007);
        apply(100, 30);
        check("bcd_100", 32'(bcd_a), 32'h100);

        // Input change mid-conversion: both values convert, in order.
        apply(0, 20);
        pulses = 0;
        apply(255, 3);
        apply(42, 40);
        check("two_pulses", 32'(pulses), 32'd2);
        check("bcd_42", 32'(bcd_a), 32'h042);

        // Reset during the 4th shift cycle of 200.
        oc = 8'd200;
        $display("apply value=200 with reset mid-conversion");
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_bcd",  32'(bcd_a),  32'h000);
        check("rst_en",   32'(en_a),   32'd1);
        check("rst_seg",  32'(seg_a),  32'h3F);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("bcd_200", 32'(bcd_a), 32'h200);

        // Random values with random hold times, including mid-conversion changes.
        for (int i = 0; i < 60; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'(oc) : int'($urandom_range(0, 255));
            apply(v, int'($urandom_range(1, 14)));
        end
        apply(int'(oc), 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nsc8_output_display.md
Name: nsc8_output_display

Overview:
Downstream consumer of the NSC8 output register. Watches the N-bit output_contents bus and converts each new value to packed BCD with a sequential shift-add-3 (double-dabble) engine. Drives a time-multiplexed common-cathode 7-segment display, with optional leading-zero blanking. Instantiated beside the NSC8 core at top level, sharing its clock.

Parameters:
N, 8, width of output_contents
DIGITS, 3, BCD digits/display positions; must satisfy 10^DIGITS > 2^N-1
SCAN_DIV, 1024, clocks each digit stays enabled (>=2)
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
output_contents  in  N  value from the NSC8 output register
bcd  out  4*DIGITS  packed BCD of last converted value, digit 0 in [3:0]
bcd_valid  out  1  one-cycle pulse when bcd updates
busy  out  1  high while conversion in progress
digit_en  out  DIGITS  one-hot active-high digit enable
seg  out  7  segments {g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, last_value=0, bcd=0, bcd_valid=0, busy=0, shift count=0, prescaler=0, scan idx=0 -> digit_en=1, seg=7'h3F.
- FSM states: IDLE, SHIFT.
- IDLE: if output_contents != last_value at a rising edge -> load binary shift reg with output_contents, clear BCD work reg, last_value<=output_contents, count<=0, go SHIFT. Otherwise stay. No conversion when value unchanged; after reset, input 0 converts nothing (bcd already 0).
- SHIFT: each cycle, add 3 to every BCD work nibble >=5, then shift {work,bin} left 1; count++. On the edge completing the N-th shift: bcd<=work result, bcd_valid=1 for the following cycle, go IDLE.
- Latency: capture edge to bcd update = N+1 edges (9 for N=8). busy high exactly in SHIFT (N cycles).
- Input changes during SHIFT ignored; re-evaluated in IDLE against last_value, so the newest value always converts eventually. Back-to-back conversions allowed: IDLE lasts at least 1 cycle between them.
- bcd holds until next conversion completes; no partial results visible.
- Scan: prescaler counts 0..SCAN_DIV-1 free-running; on wrap, idx advances, DIGITS-1 wraps to 0. digit_en = one-hot(idx), combinational from the idx register.
- seg decoded combinationally from bcd nibble idx: 0-9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F; nibbles >9 (unreachable) -> 00.
- Blanking (BLANK_LZ=1): digit k>0 shows seg=00 if nibbles k..DIGITS-1 are all zero. digit_en still asserts for blanked digits.
- Scan runs independently of conversion; a bcd update mid-dwell changes seg immediately.
- reset_n low mid-conversion: abort, all registers to reset values; after release, a nonzero input restarts conversion.

Test Plan:
- Reset then output_contents=0 held 50 cycles -> busy never rises, bcd=0x000, bcd_valid never pulses, digit_en scans 1,2,4 with seg 3F,00,00.
- output_contents 0->255 -> busy high 8 cycles, bcd=0x255 with bcd_valid pulse 9 edges after capture; scan shows 6D on digit 0, 6D on digit 1, 5B on digit 2.
- output_contents=7, BLANK_LZ=1 -> bcd=0x007; digit 0 seg 07, digits 1,2 seg 00; repeat with BLANK_LZ=0 -> digits 1,2 show 3F. Value 100 -> digits 3F,3F,06 (inner zeros not blanked).
- 255 then 42 applied 3 cycles into conversion -> first bcd_valid with 0x255, then second conversion starts, bcd=0x042 after second pulse; exactly two pulses.
- SCAN_DIV=4, run 24 cycles -> digit_en changes every 4 cycles, sequence 1,2,4,1,2,4, never zero or multi-hot.
- Assert reset_n low at 4th SHIFT cycle of 200 -> busy=0, bcd=0 immediately; release with input still 200 -> fresh conversion, bcd=0x200 after 9 edges.
